wfm_capture_seq: RTL
====================

// Module: wfm_capture_seq
// PURPOSE
//  Capture sequencer for the waveform buffer on the picorv32 SoC. Firmware configures it via CSRs; it then runs arm -> pre-trigger -> wait -> post-trigger.
//  It generates write enables, addresses and round-robin channel selects for the shared circular sample RAM, so a single RAM port is shared by N_CH channels.
//  Firmware polls done and trig_addr and unwraps the buffer over the bus.
// PARAMETERS
//  AW    9  buffer address width; buffer depth = 2**AW words
//  N_CH  2  number of ADC channels sharing the buffer (1..8)
//  CW    1  channel-select width, >= clog2(N_CH), min 1
// PORTS
//  clk        in   1     single clock (bus and sample domain)
//  rst        in   1     synchronous, active-high reset
//  arm        in   1     one-cycle pulse: start/restart a capture
//  sw_trig    in   1     software trigger pulse
//  ext_trig   in   1     external trigger level, synchronous to clk
//  trig_sel   in   2     0=sw, 1=ext rising edge, 2=sw|ext, 3=auto (immediate)
//  pre_len    in   AW    pre-trigger sample count (words)
//  decim      in   8     write one word every decim+1 cycles
//  ch_mask    in   N_CH  enabled channels for round-robin
//  wr_en      out  1     RAM write strobe
//  wr_addr    out  AW    RAM write address
//  wr_ch      out  CW    channel whose sample is written this strobe
//  state      out  2     0=IDLE 1=PRE 2=WAIT 3=POST
//  done       out  1     sticky, set at capture completion
//  trig_addr  out  AW    address of first post-trigger word
// BEHAVIOUR
//  Reset: all outputs 0, state=IDLE, internal ptr/dcnt/postcnt/ext_q=0.
//  Outputs are registered; arm/cfg are sampled at posedge.
//  arm in any state: ptr<=0, dcnt<=0, done<=0, rr pointer to lowest set ch_mask bit.
//    Next state is PRE, or WAIT if pre_len==0. An arm during a capture aborts it and restarts.
//  Tick: state!=IDLE && dcnt==0 && ch_mask!=0.
//    On a tick: dcnt<=decim, else dcnt<=dcnt-1 (saturate at 0).
//  Tick cycle effects:
//    - wr_en<=1, wr_addr<=ptr, ptr<=ptr+1 (mod 2**AW, wraps silently).
//    - wr_ch<=current rr channel; rr then advances to the next set bit above it, wrapping to the lowest.
//    - wr_en is 0 on all non-tick cycles.
//  Latency: first wr_en is 2 cycles after the arm cycle when decim=0.
//  ch_mask==0: no ticks. The sequencer stalls in its state with counters frozen.
//    Resumes when the mask becomes nonzero.
//  ch_mask changed mid-capture: used from the next rr advance.
//    A disabled current channel is skipped at that advance.
//  decim changed mid-capture: takes effect at the next reload.
//  PRE: counts ticks. After the pre_len-th tick -> WAIT. Triggers in PRE are ignored.
//  WAIT: keeps writing circularly. Trigger qualify per trig_sel:
//    - sw_trig=1.
//    - ext rise = ext_trig & ~ext_q, where ext_q is ext_trig registered every cycle (incl. IDLE).
//    - auto = first cycle in WAIT.
//  On trigger: trig_addr <= ptr value after any same-cycle tick, postcnt <= 2**AW - pre_len, -> POST.
//    A same-cycle tick is counted as pre-trigger.
//  POST: each tick decrements postcnt. On the tick that reaches 0 -> IDLE, done<=1 (same edge as final wr_en).
//  IDLE: no writes. done and trig_addr hold until the next arm or rst.
//  rst mid-capture: immediate return to reset values; no further writes.
// TESTING  (bench uses AW=4, N_CH=2)
//  arm, pre_len=4, decim=0, mask=2'b11, trig_sel=0, sw_trig 10 cycles later:
//    -> wr_addr 0,1,2,.. wr_ch 0,1,0,1; trig_addr=ptr at trigger; exactly 12 post writes; done=1; state=0.
//  trig_sel=1, ext_trig pulsed during PRE, then rising in WAIT:
//    -> PRE pulse ignored; trigger on WAIT edge. A held-high ext_trig gives no second trigger.
//  decim=3, trig_sel=3, pre_len=0:
//    -> wr_en every 4th cycle; immediate POST; 16 writes; addresses 0..15; done.
//  mask=2'b10:
//    -> wr_ch always 1. mask=0 mid-POST stalls with no wr_en and state/postcnt frozen; restoring the mask completes the capture.
//  re-arm mid-POST:
//    -> done stays 0, ptr restarts at 0, state PRE. rst mid-WAIT: all outputs 0 the next cycle.
//  pre_len=15, long WAIT (>3 wraps), then sw_trig:
//    -> addresses wrap 15->0; exactly 1 post write; trig_addr is correct after wrap.

Source files
------------

// File: rtl/wfm_capture_seq.sv
// Capture sequencer for a shared circular waveform buffer: arm -> pre-trigger -> wait -> post-trigger,
// producing RAM write strobes, addresses and round-robin channel selects.
module wfm_capture_seq #(
    parameter int AW   = 9,
    parameter int N_CH = 2,
    parameter int CW   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            arm,
    input  logic            sw_trig,
    input  logic            ext_trig,
    input  logic [1:0]      trig_sel,
    input  logic [AW-1:0]   pre_len,
    input  logic [7:0]      decim,
    input  logic [N_CH-1:0] ch_mask,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [CW-1:0]   wr_ch,
    output logic [1:0]      state,
    output logic            done,
    output logic [AW-1:0]   trig_addr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_POST = 2'd3;

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] ptr;
    logic [AW-1:0] ptr_inc;
    logic [7:0]    dcnt;
    logic [AW:0]   postcnt;
    logic          ext_q;
    logic [CW-1:0] rr;
    logic [CW-1:0] cur_ch;
    logic          mask_any;
    logic          tick;
    logic          ext_rise;
    logic          trig_hit;

    // Next enabled channel strictly above cur, wrapping; returns cur if none enabled.
    function automatic logic [CW-1:0] next_set(input logic [CW-1:0] cur, input logic [N_CH-1:0] m);
        logic [CW-1:0] res;
        logic          found;
        int            idx;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(cur) + k) % N_CH;
            if (m[idx] && !found) begin
                res   = CW'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [CW-1:0] lowest_set(input logic [N_CH-1:0] m);
        logic [CW-1:0] res;
        res = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i]) res = CW'(i);
        end
        return res;
    endfunction

    always_comb begin
        mask_any = |ch_mask;
        tick     = (state != S_IDLE) && (dcnt == 8'd0) && mask_any;
        ptr_inc  = ptr + 1'b1;
        ext_rise = ext_trig & ~ext_q;
        // A channel disabled while it is the current pick is skipped, not written.
        cur_ch   = ch_mask[rr] ? rr : next_set(rr, ch_mask);
        trig_hit = 1'b0;
        case (trig_sel)
            2'd0:    trig_hit = sw_trig;
            2'd1:    trig_hit = ext_rise;
            2'd2:    trig_hit = sw_trig | ext_rise;
            default: trig_hit = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) ext_q <= 1'b0;
        else     ext_q <= ext_trig;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_ch     <= '0;
            done      <= 1'b0;
            trig_addr <= '0;
            ptr       <= '0;
            dcnt      <= '0;
            postcnt   <= '0;
            rr        <= '0;
        end else if (arm) begin
            state <= (pre_len == '0) ? S_WAIT : S_PRE;
            wr_en <= 1'b0;
            done  <= 1'b0;
            ptr   <= '0;
            dcnt  <= '0;
            rr    <= lowest_set(ch_mask);
        end else begin
            wr_en <= tick;
            // With no channel enabled everything freezes, including the decimation count.
            if (state != S_IDLE && mask_any) begin
                if (tick)              dcnt <= decim;
                else if (dcnt != 8'd0) dcnt <= dcnt - 8'd1;
            end
            if (tick) begin
                wr_addr <= ptr;
                ptr     <= ptr_inc;
                wr_ch   <= cur_ch;
                rr      <= next_set(cur_ch, ch_mask);
            end
            case (state)
                S_PRE: begin
                    if (tick && ptr_inc == pre_len) state <= S_WAIT;
                end
                S_WAIT: begin
                    // A tick on the trigger cycle belongs to the pre-trigger segment.
                    if (trig_hit && mask_any) begin
                        trig_addr <= tick ? ptr_inc : ptr;
                        postcnt   <= DEPTH - {1'b0, pre_len};
                        state     <= S_POST;
                    end
                end
                S_POST: begin
                    if (tick) begin
                        postcnt <= postcnt - 1'b1;
                        if (postcnt == {{AW{1'b0}}, 1'b1}) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
